// File: rtl/hazard_stall_unit.sv
// Pipeline hazard detector for a 5-stage MIPS-style core with branches resolved in ID.
// Produces stall/bubble/flush controls and keeps saturating stall and flush statistics.
module hazard_stall_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  IF_ID_RS,
    input  logic [4:0]  IF_ID_RT,
    input  logic        ID_USES_RT,
    input  logic        ID_BRANCH,
    input  logic        ID_JUMP,
    input  logic        BRANCH_TAKEN,
    input  logic [4:0]  ID_EX_WRITE_REG,
    input  logic        ID_EX_REGWRITE,
    input  logic        ID_EX_MEMREAD,
    input  logic [4:0]  EX_MEM_WRITE_REG,
    input  logic        EX_MEM_MEMREAD,
    output logic        PC_WRITE,
    output logic        IF_ID_WRITE,
    output logic        ID_EX_BUBBLE,
    output logic        IF_ID_FLUSH,
    output logic [15:0] STALL_CYCLES,
    output logic [15:0] FLUSH_COUNT
);

    typedef enum logic {RUN, HOLD} state_t;

    state_t      state_reg;
    logic [1:0]  rem_reg;
    logic [15:0] stall_cnt_reg;
    logic [15:0] flush_cnt_reg;

    logic        ex_match;
    logic        mem_match;
    logic [1:0]  need;

    // Register 0 is hard-wired to zero, so it never matches a source operand.
    function automatic logic src_match(
        input logic [4:0] x,
        input logic [4:0] rs,
        input logic [4:0] rt,
        input logic       uses_rt
    );
        return (x != 5'd0) && ((x == rs) || (uses_rt && (x == rt)));
    endfunction

    always_comb begin
        ex_match  = src_match(ID_EX_WRITE_REG, IF_ID_RS, IF_ID_RT, ID_USES_RT);
        mem_match = src_match(EX_MEM_WRITE_REG, IF_ID_RS, IF_ID_RT, ID_USES_RT);
        need      = 2'd0;
        if (ID_EX_MEMREAD && ex_match)
            need = 2'd1;
        if (ID_BRANCH && ID_EX_REGWRITE && !ID_EX_MEMREAD && ex_match)
            need = 2'd1;
        if (ID_BRANCH && EX_MEM_MEMREAD && mem_match)
            need = 2'd1;
        // A branch waiting on a load still in EX needs the longest wait.
        if (ID_BRANCH && ID_EX_MEMREAD && ex_match)
            need = 2'd2;
    end

    // Stall controls are combinational so the hazard is covered in the cycle it is seen.
    always_comb begin
        PC_WRITE     = 1'b1;
        IF_ID_WRITE  = 1'b1;
        ID_EX_BUBBLE = 1'b0;
        IF_ID_FLUSH  = 1'b0;
        if (!rst) begin
            if (state_reg == HOLD || need != 2'd0) begin
                PC_WRITE     = 1'b0;
                IF_ID_WRITE  = 1'b0;
                ID_EX_BUBBLE = 1'b1;
            end else begin
                IF_ID_FLUSH = (ID_BRANCH && BRANCH_TAKEN) || ID_JUMP;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= RUN;
            rem_reg       <= 2'd0;
            stall_cnt_reg <= 16'd0;
            flush_cnt_reg <= 16'd0;
        end else begin
            case (state_reg)
                RUN: begin
                    if (need == 2'd2) begin
                        state_reg <= HOLD;
                        rem_reg   <= 2'd1;
                    end
                end
                HOLD: begin
                    rem_reg <= rem_reg - 2'd1;
                    if (rem_reg <= 2'd1)
                        state_reg <= RUN;
                end
                default: begin
                    state_reg <= RUN;
                    rem_reg   <= 2'd0;
                end
            endcase
            if (!PC_WRITE && stall_cnt_reg != 16'hFFFF)
                stall_cnt_reg <= stall_cnt_reg + 16'd1;
            if (IF_ID_FLUSH && flush_cnt_reg != 16'hFFFF)
                flush_cnt_reg <= flush_cnt_reg + 16'd1;
        end
    end

    assign STALL_CYCLES = stall_cnt_reg;
    assign FLUSH_COUNT  = flush_cnt_reg;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit: load-use, branch hazards, flushes, reset in HOLD, saturation.
module tb_hazard_stall_unit;

    logic        clk;
    logic        rst;
    logic [4:0]  IF_ID_RS;
    logic [4:0]  IF_ID_RT;
    logic        ID_USES_RT;
    logic        ID_BRANCH;
    logic        ID_JUMP;
    logic        BRANCH_TAKEN;
    logic [4:0]  ID_EX_WRITE_REG;
    logic        ID_EX_REGWRITE;
    logic        ID_EX_MEMREAD;
    logic [4:0]  EX_MEM_WRITE_REG;
    logic        EX_MEM_MEMREAD;
    logic        PC_WRITE;
    logic        IF_ID_WRITE;
    logic        ID_EX_BUBBLE;
    logic        IF_ID_FLUSH;
    logic [15:0] STALL_CYCLES;
    logic [15:0] FLUSH_COUNT;

    int total;
    int bad;

    hazard_stall_unit dut (
        .clk              (clk),
        .rst              (rst),
        .IF_ID_RS         (IF_ID_RS),
        .IF_ID_RT         (IF_ID_RT),
        .ID_USES_RT       (ID_USES_RT),
        .ID_BRANCH        (ID_BRANCH),
        .ID_JUMP          (ID_JUMP),
        .BRANCH_TAKEN     (BRANCH_TAKEN),
        .ID_EX_WRITE_REG  (ID_EX_WRITE_REG),
        .ID_EX_REGWRITE   (ID_EX_REGWRITE),
        .ID_EX_MEMREAD    (ID_EX_MEMREAD),
        .EX_MEM_WRITE_REG (EX_MEM_WRITE_REG),
        .EX_MEM_MEMREAD   (EX_MEM_MEMREAD),
        .PC_WRITE         (PC_WRITE),
        .IF_ID_WRITE      (IF_ID_WRITE),
        .ID_EX_BUBBLE     (ID_EX_BUBBLE),
        .IF_ID_FLUSH      (IF_ID_FLUSH),
        .STALL_CYCLES     (STALL_CYCLES),
        .FLUSH_COUNT      (FLUSH_COUNT)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic clear_inputs();
        IF_ID_RS = 5'd0; IF_ID_RT = 5'd0; ID_USES_RT = 1'b0;
        ID_BRANCH = 1'b0; ID_JUMP = 1'b0; BRANCH_TAKEN = 1'b0;
        ID_EX_WRITE_REG = 5'd0; ID_EX_REGWRITE = 1'b0; ID_EX_MEMREAD = 1'b0;
        EX_MEM_WRITE_REG = 5'd0; EX_MEM_MEMREAD = 1'b0;
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_stall(input string tag, input logic stall);
        check({tag, ".pc_write"}, {31'd0, PC_WRITE}, {31'd0, !stall});
        check({tag, ".if_id_write"}, {31'd0, IF_ID_WRITE}, {31'd0, !stall});
        check({tag, ".bubble"}, {31'd0, ID_EX_BUBBLE}, {31'd0, stall});
    endtask

    task automatic load_ex_branch();
        ID_BRANCH = 1'b1; ID_EX_MEMREAD = 1'b1; ID_EX_WRITE_REG = 5'd9;
        IF_ID_RT = 5'd9; ID_USES_RT = 1'b1; BRANCH_TAKEN = 1'b1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        clear_inputs();
        rst = 1'b1;
        // Reset with a live hazard and a jump present: outputs must stay non-stall.
        ID_EX_MEMREAD = 1'b1; ID_EX_WRITE_REG = 5'd8; IF_ID_RS = 5'd8; ID_JUMP = 1'b1;
        tick();
        check_stall("rst_outputs", 1'b0);
        check("rst_flush", {31'd0, IF_ID_FLUSH}, 32'd0);
        tick();
        check("rst_stall_cnt", {16'd0, STALL_CYCLES}, 32'd0);
        check("rst_flush_cnt", {16'd0, FLUSH_COUNT}, 32'd0);
        rst = 1'b0;
        clear_inputs();
        #1;
        check_stall("idle", 1'b0);

        // Load-use on rs
        ID_EX_MEMREAD = 1'b1; ID_EX_WRITE_REG = 5'd8; IF_ID_RS = 5'd8;
        #1;
        check_stall("load_use", 1'b1);
        tick();
        clear_inputs();
        #1;
        check_stall("load_use_after", 1'b0);
        check("load_use_cnt", {16'd0, STALL_CYCLES}, 32'd1);

        // Register 0 never stalls
        ID_EX_MEMREAD = 1'b1; ID_EX_WRITE_REG = 5'd0; IF_ID_RS = 5'd0;
        IF_ID_RT = 5'd0; ID_USES_RT = 1'b1; ID_BRANCH = 1'b1;
        EX_MEM_MEMREAD = 1'b1; EX_MEM_WRITE_REG = 5'd0;
        #1;
        check_stall("zero_reg", 1'b0);
        tick();
        clear_inputs();
        #1;
        check("zero_reg_cnt", {16'd0, STALL_CYCLES}, 32'd1);

        // Branch on load in EX: two stall cycles, HOLD ignores inputs
        load_ex_branch();
        #1;
        check_stall("br_load_ex_c1", 1'b1);
        check("br_load_ex_c1_flush", {31'd0, IF_ID_FLUSH}, 32'd0);
        tick();
        clear_inputs();
        ID_JUMP = 1'b1; ID_BRANCH = 1'b1; BRANCH_TAKEN = 1'b1;
        #1;
        check_stall("br_load_ex_hold", 1'b1);
        check("br_load_ex_hold_flush", {31'd0, IF_ID_FLUSH}, 32'd0);
        tick();
        clear_inputs();
        #1;
        check_stall("br_load_ex_done", 1'b0);
        check("br_load_ex_cnt", {16'd0, STALL_CYCLES}, 32'd3);
        check("br_load_ex_fcnt", {16'd0, FLUSH_COUNT}, 32'd0);

        // Taken branch, no hazard
        ID_BRANCH = 1'b1; BRANCH_TAKEN = 1'b1;
        #1;
        check("taken_flush", {31'd0, IF_ID_FLUSH}, 32'd1);
        check_stall("taken", 1'b0);
        tick();
        clear_inputs();
        #1;
        check("taken_flush_off", {31'd0, IF_ID_FLUSH}, 32'd0);
        check("taken_fcnt", {16'd0, FLUSH_COUNT}, 32'd1);

        // Not-taken branch does not flush
        ID_BRANCH = 1'b1;
        #1;
        check("not_taken_flush", {31'd0, IF_ID_FLUSH}, 32'd0);

        // Jump together with taken branch: one flush cycle
        ID_JUMP = 1'b1; BRANCH_TAKEN = 1'b1;
        #1;
        check("jump_br_flush", {31'd0, IF_ID_FLUSH}, 32'd1);
        tick();
        clear_inputs();
        #1;
        check("jump_br_fcnt", {16'd0, FLUSH_COUNT}, 32'd2);

        // Taken branch hazarded by ALU result: stall first, flush when it resolves
        ID_BRANCH = 1'b1; BRANCH_TAKEN = 1'b1; ID_EX_REGWRITE = 1'b1;
        ID_EX_WRITE_REG = 5'd5; IF_ID_RS = 5'd5;
        #1;
        check_stall("br_alu", 1'b1);
        check("br_alu_flush", {31'd0, IF_ID_FLUSH}, 32'd0);
        tick();
        ID_EX_REGWRITE = 1'b0; ID_EX_WRITE_REG = 5'd0;
        #1;
        check_stall("br_alu_resolved", 1'b0);
        check("br_alu_resolved_flush", {31'd0, IF_ID_FLUSH}, 32'd1);
        tick();
        clear_inputs();
        #1;
        check("br_alu_cnt", {16'd0, STALL_CYCLES}, 32'd4);
        check("br_alu_fcnt", {16'd0, FLUSH_COUNT}, 32'd3);

        // Branch on load in MEM: rt only matters when the instruction reads it
        ID_BRANCH = 1'b1; EX_MEM_MEMREAD = 1'b1; EX_MEM_WRITE_REG = 5'd7; IF_ID_RT = 5'd7;
        #1;
        check_stall("br_mem_no_rt", 1'b0);
        ID_USES_RT = 1'b1;
        #1;
        check_stall("br_mem_rt", 1'b1);
        tick();
        clear_inputs();
        #1;
        check_stall("br_mem_after", 1'b0);
        check("br_mem_cnt", {16'd0, STALL_CYCLES}, 32'd5);

        // Load in EX without a branch is a plain one-cycle load-use
        ID_EX_MEMREAD = 1'b1; ID_EX_WRITE_REG = 5'd9; IF_ID_RT = 5'd9; ID_USES_RT = 1'b1;
        #1;
        check_stall("load_rt", 1'b1);
        tick();
        clear_inputs();
        #1;
        check_stall("load_rt_after", 1'b0);

        // Reset while in HOLD
        load_ex_branch();
        tick();
        clear_inputs();
        #1;
        check_stall("pre_rst_hold", 1'b1);
        rst = 1'b1;
        #1;
        check_stall("rst_in_hold", 1'b0);
        tick();
        rst = 1'b0;
        #1;
        check_stall("post_rst_run", 1'b0);
        check("post_rst_cnt", {16'd0, STALL_CYCLES}, 32'd0);
        check("post_rst_fcnt", {16'd0, FLUSH_COUNT}, 32'd0);

        // Saturation: hold a load-use hazard for 70000 cycles
        ID_EX_MEMREAD = 1'b1; ID_EX_WRITE_REG = 5'd8; IF_ID_RS = 5'd8;
        for (int i = 0; i < 70000; i++)
            tick();
        check("sat_cnt", {16'd0, STALL_CYCLES}, 32'h0000FFFF);
        tick();
        check("sat_no_wrap", {16'd0, STALL_CYCLES}, 32'h0000FFFF);
        check("sat_fcnt", {16'd0, FLUSH_COUNT}, 32'd0);
        clear_inputs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
